// File: rtl/wb_fifo.sv
// Small circular buffer for long-latency writeback results.
// The head entry becomes visible the cycle after it is pushed; pushes while full are dropped.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, long-latency results queue in
// wb_fifo, and a per-register busy scoreboard produces the issue hazard stall.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif

module wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = `ARCH_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [`REG_IDX_W-1:0]       alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [`REG_IDX_W-1:0]       lsu_rd,
    input  logic [XLEN-1:0]             lsu_data,
    input  logic                        issue_valid,
    input  logic                        issue_long,
    input  logic [`REG_IDX_W-1:0]       issue_rd,
    input  logic [`REG_IDX_W-1:0]       rs1,
    input  logic [`REG_IDX_W-1:0]       rs2,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    output logic                        hazard_stall,
    output logic                        rf_we,
    output logic [`REG_IDX_W-1:0]       rf_rd,
    output logic [XLEN-1:0]             rf_data,
    output logic [(1<<`REG_IDX_W)-1:0]  busy_mask
);
    localparam int RW   = `REG_IDX_W;
    localparam int NREG = 1 << RW;
    localparam int EW   = RW + XLEN;

    logic [EW-1:0]            w_head;
    logic [RW-1:0]            w_head_rd;
    logic [XLEN-1:0]          w_head_data;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_unused_count;
    logic                     w_push;
    logic                     w_pop;
    logic [NREG-1:0]          w_busy_set;
    logic [NREG-1:0]          w_busy_clr;
    logic [NREG-1:0]          w_busy_nxt;
    logic                     w_raw_busy;
    logic                     w_waw_busy;
    logic                     w_in_flight;

    logic                     r_rf_we;
    logic [RW-1:0]            r_rf_rd;
    logic [XLEN-1:0]          r_rf_data;
    logic [NREG-1:0]          r_busy;

    assign w_push      = lsu_valid && !w_full;
    assign w_pop       = !alu_valid && !w_empty;
    assign w_head_rd   = w_head[EW-1:XLEN];
    assign w_head_data = w_head[XLEN-1:0];

    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({lsu_rd, lsu_data}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_unused_count)
    );

    // No bypass path: a write still sitting on the rf port stalls its readers too
    assign w_raw_busy  = (rs1_used && rs1 != '0 && r_busy[rs1]) ||
                         (rs2_used && rs2 != '0 && r_busy[rs2]);
    assign w_waw_busy  = issue_valid && issue_rd != '0 && r_busy[issue_rd];
    assign w_in_flight = r_rf_we && r_rf_rd != '0 &&
                         ((rs1_used && rs1 == r_rf_rd) || (rs2_used && rs2 == r_rf_rd));
    assign hazard_stall = w_raw_busy || w_waw_busy || w_in_flight;

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid && issue_long && !hazard_stall && issue_rd != '0)
            w_busy_set[issue_rd] = 1'b1;
        if (w_pop)
            w_busy_clr[w_head_rd] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
            r_busy    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (alu_valid) begin
                r_rf_we   <= (alu_rd != '0);
                r_rf_rd   <= alu_rd;
                r_rf_data <= alu_data;
            end else if (w_pop) begin
                r_rf_we   <= (w_head_rd != '0);
                r_rf_rd   <= w_head_rd;
                r_rf_data <= w_head_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign lsu_ready = !w_full;
    assign rf_we     = r_rf_we;
    assign rf_rd     = r_rf_rd;
    assign rf_data   = r_rf_data;
    assign busy_mask = r_busy;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, long-latency result buffer entries (power of two, >=2).
REQ-002 Parameter: XLEN, default `ARCH_WIDTH, data width.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 alu_valid  in  1  single-cycle result present; this path cannot be back-pressured.
REQ-006 alu_rd  in  5  destination register of the ALU result.
REQ-007 alu_data  in  XLEN  ALU result.
REQ-008 lsu_valid  in  1  long-latency (load/mul/div) result offered.
REQ-009 lsu_ready  out  1  long-latency result accepted this cycle when lsu_valid=1.
REQ-010 lsu_rd  in  5  and lsu_data  in  XLEN: long-latency destination register and value.
REQ-011 issue_valid  in  1  and issue_long  in  1: instruction issues this cycle; issue_long=1 marks a long-latency op.
REQ-012 issue_rd  in  5  destination register of the issuing instruction.
REQ-013 rs1, rs2  in  5 each, and rs1_used, rs2_used  in  1 each: source operands of the issuing instruction.
REQ-014 hazard_stall  out  1  issue must be held this cycle.
REQ-015 rf_we  out  1, rf_rd  out  5, rf_data  out  XLEN: register-file write port (drives we/rd/data_in).
REQ-016 busy_mask  out  32  per-register pending long-latency write flags.

Function
REQ-017 Writeback latency: one cycle; the winner in cycle N appears on rf_* in cycle N+1, registered.
REQ-018 Priority: alu_valid=1 wins the write port; otherwise the FIFO head is written; otherwise rf_we=0.
REQ-019 Accepted lsu results enter a FIFO_DEPTH-entry FIFO; lsu_ready = FIFO not full, combinational, independent of alu_valid.
REQ-020 FIFO full with a pop in the same cycle: lsu_ready stays 0; no same-cycle pass-through.
REQ-021 FIFO empty with push: the entry is eligible for writeback no earlier than the next cycle.
REQ-022 Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 Results with rd=0 from either path produce rf_we=0 and are consumed normally (FIFO popped).
REQ-024 busy_mask[r] sets when issue_valid && issue_long && !hazard_stall && issue_rd=r && r!=0.
REQ-025 busy_mask[r] clears on the edge where the FIFO entry for r is popped to the write port.
REQ-026 Set and clear of the same r in the same cycle: set wins.
REQ-027 busy_mask[0] is always 0.
REQ-028 hazard_stall=1 if (rs1_used && busy[rs1]) || (rs2_used && busy[rs2]) || (issue_valid && busy[issue_rd]) (WAW), with rs/rd = 0 excluded.
REQ-029 hazard_stall=1 also if rf_we && a used rs1/rs2 equals rf_rd != 0 (write in flight, no bypass).
REQ-030 hazard_stall is combinational from inputs and state; it never gates alu_valid.
REQ-031 Data width: rf_data carries XLEN bits unmodified; no extension performed here.

Reset
REQ-032 On rst: rf_we=0, rf_rd=0, rf_data=0, busy_mask=0, FIFO empty (lsu_ready=1), pointers=0.
REQ-033 rst mid-operation discards all buffered results and pending flags; first post-reset write needs no drain.
REQ-034 rst has priority over every concurrent push, pop, set or clear.

Structure
REQ-035 XLEN and register-index width constants come from the shared common include; no new package.
REQ-036 The FIFO is a sub-module named wb_fifo (parameterised depth and width, push/pop/full/empty/count).
REQ-037 Scoreboard, arbitration and output registers reside in wb_arbiter; no latches, no combinational loops.

Verification
REQ-038 alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_data=0x1234.
REQ-039 Long issue rd=7; next cycle rs1=7 used -> hazard_stall=1; lsu result 0xABCD rd=7 -> written, busy[7]=0, stall drops one cycle after rf_we.
REQ-040 alu_valid held 4 cycles while 3 lsu results arrive, FIFO_DEPTH=2 -> lsu_ready=0 on the third; after ALU stops, results written in arrival order.
REQ-041 Pop of rd=3 and new long issue rd=3 in the same cycle -> busy[3] remains 1.
REQ-042 rst asserted with FIFO full and busy_mask=0x00000880 -> next cycle all outputs 0, lsu_ready=1.
REQ-043 lsu result rd=0, data 0xFFFF -> FIFO popped, rf_we stays 0.
